// File: rtl/cdb_arbiter.sv
// Single-owner scheduler for the shared 12-bit CDB: rotating priority across the
// functional units, with an aging override that guarantees PRF re-broadcasts progress.
module cdb_arbiter #(
  parameter int NUM_FU  = 3,
  parameter int AGE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_FU-1:0]      fu_valid,
  input  logic [NUM_FU-1:0][3:0] fu_id,
  input  logic [NUM_FU-1:0][7:0] fu_val,
  output logic [NUM_FU-1:0]      fu_ready,
  input  logic                   prf_req_valid,
  input  logic [3:0]             prf_req_id,
  output logic                   prf_req_ready,
  output logic                   prf_requesting,
  output logic [3:0]             prf_requested_id,
  input  logic                   prf_cdb_transmit,
  input  logic [3:0]             prf_cdb_id,
  input  logic [7:0]             prf_cdb_val,
  output logic                   cdb_transmit,
  output logic [3:0]             cdb_id,
  output logic [7:0]             cdb_val
);

  localparam int         PTR_W   = $clog2(NUM_FU);
  localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);
  localparam logic [3:0] AGE_SAT = 4'd15;

  logic [PTR_W-1:0] rr_ptr;
  logic [3:0]       age_cnt;
  logic             prf_aged;
  logic             fu_any;
  logic             fu_win;
  logic             prf_win;
  logic [PTR_W-1:0] fu_sel;

  logic             cdb_vld_p1;
  logic [3:0]       cdb_id_p1;
  logic [7:0]       cdb_val_p1;

  function automatic logic [3:0] age_sat_inc(input logic [3:0] a);
    return (a == AGE_SAT) ? AGE_SAT : a + 4'd1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_FU - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_FU) s = s - NUM_FU;
    return PTR_W'(s);
  endfunction

  // Stage p0: combinational grant selection
  always_comb begin
    fu_any = 1'b0;
    fu_sel = '0;
    // Walk the ring backwards so the last hit is the one nearest rr_ptr.
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      if (fu_valid[rot_idx(rr_ptr, k)]) begin
        fu_any = 1'b1;
        fu_sel = rot_idx(rr_ptr, k);
      end
    end
  end

  assign prf_aged = prf_req_valid && (age_cnt >= AGE_LIM);
  assign fu_win   = fu_any && !prf_aged;
  assign prf_win  = prf_aged || (prf_req_valid && !fu_any);

  always_comb begin
    fu_ready = '0;
    if (fu_win) fu_ready[fu_sel] = 1'b1;
  end

  assign prf_req_ready    = prf_win;
  assign prf_requesting   = prf_win;
  assign prf_requested_id = prf_win ? prf_req_id : 4'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= '0;
      age_cnt <= 4'd0;
    end else begin
      if (fu_win) rr_ptr <= ptr_wrap_inc(fu_sel);
      if (!prf_req_valid || prf_win) age_cnt <= 4'd0;
      else                           age_cnt <= age_sat_inc(age_cnt);
    end
  end

  // Stage p1: registered CDB broadcast
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_vld_p1 <= 1'b0;
      cdb_id_p1  <= 4'd0;
      cdb_val_p1 <= 8'd0;
    end else if (fu_win) begin
      cdb_vld_p1 <= 1'b1;
      cdb_id_p1  <= fu_id[fu_sel];
      cdb_val_p1 <= fu_val[fu_sel];
    end else if (prf_win && prf_cdb_transmit) begin
      cdb_vld_p1 <= 1'b1;
      cdb_id_p1  <= prf_cdb_id;
      cdb_val_p1 <= prf_cdb_val;
    end else begin
      cdb_vld_p1 <= 1'b0;
      cdb_id_p1  <= 4'd0;
      cdb_val_p1 <= 8'd0;
    end
  end

  assign cdb_transmit = cdb_vld_p1;
  assign cdb_id       = cdb_id_p1;
  assign cdb_val      = cdb_val_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios then constrained-random traffic,
// checked against a rule-level arbitration model with a PRF memory behind the read port.
module tb_cdb_arbiter;

  localparam int N    = 3;
  localparam int AMAX = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        fu_valid;
  logic [N-1:0][3:0]   fu_id;
  logic [N-1:0][7:0]   fu_val;
  logic [N-1:0]        fu_ready;
  logic                prf_req_valid;
  logic [3:0]          prf_req_id;
  logic                prf_req_ready;
  logic                prf_requesting;
  logic [3:0]          prf_requested_id;
  logic                prf_cdb_transmit;
  logic [3:0]          prf_cdb_id;
  logic [7:0]          prf_cdb_val;
  logic                cdb_transmit;
  logic [3:0]          cdb_id;
  logic [7:0]          cdb_val;

  typedef struct packed {
    logic       t;
    logic [3:0] id;
    logic [7:0] val;
  } cdb_t;

  cdb_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] prf_mem [16];
  logic       force_low;
  int         m_rr;
  int         m_age;
  logic       last_prf_rdy;

  always #5 clk = ~clk;

  // PRF read port: combinational echo of the requested entry
  assign prf_cdb_transmit = prf_requesting & ~force_low;
  assign prf_cdb_id       = prf_requested_id;
  assign prf_cdb_val      = prf_mem[prf_requested_id];

  cdb_arbiter #(.NUM_FU(N), .AGE_MAX(AMAX)) dut (
    .clk(clk), .rst(rst),
    .fu_valid(fu_valid), .fu_id(fu_id), .fu_val(fu_val), .fu_ready(fu_ready),
    .prf_req_valid(prf_req_valid), .prf_req_id(prf_req_id), .prf_req_ready(prf_req_ready),
    .prf_requesting(prf_requesting), .prf_requested_id(prf_requested_id),
    .prf_cdb_transmit(prf_cdb_transmit), .prf_cdb_id(prf_cdb_id), .prf_cdb_val(prf_cdb_val),
    .cdb_transmit(cdb_transmit), .cdb_id(cdb_id), .cdb_val(cdb_val)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns winning FU index, N for the PRF, -1 for no grant.
  function automatic int model_winner(input logic [N-1:0] v, input logic pv);
    if (pv && m_age >= AMAX) return N;
    for (int k = 0; k < N; k++)
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    if (pv) return N;
    return -1;
  endfunction

  task automatic run_cycle(input logic [N-1:0] v, input logic [N-1:0][3:0] ids,
                           input logic [N-1:0][7:0] vals, input logic pv,
                           input logic [3:0] pid, input logic fl, output int w);
    logic [N-1:0] exp_rdy;
    cdb_t         e;
    fu_valid      = v;
    fu_id         = ids;
    fu_val        = vals;
    prf_req_valid = pv;
    prf_req_id    = pid;
    force_low     = fl;
    w = model_winner(v, pv);
    exp_rdy = '0;
    if (w >= 0 && w < N) exp_rdy[w] = 1'b1;
    #1;
    check("fu_ready", 32'(fu_ready), 32'(exp_rdy));
    check("prf_req_ready", 32'(prf_req_ready), 32'(w == N));
    check("prf_requesting", 32'(prf_requesting), 32'(w == N));
    check("prf_requested_id", 32'(prf_requested_id), (w == N) ? 32'(pid) : 32'd0);
    last_prf_rdy = prf_req_ready;
    e = '0;
    if (w >= 0 && w < N) begin
      e.t = 1'b1; e.id = ids[w]; e.val = vals[w];
      m_rr = (w + 1) % N;
    end else if (w == N && !fl) begin
      e.t = 1'b1; e.id = pid; e.val = prf_mem[pid];
    end
    sb_q.push_back(e);
    if (!pv || w == N) m_age = 0;
    else if (m_age < 15) m_age++;
    @(negedge clk);
  endtask

  // Monitor: compares the registered CDB every cycle against the scoreboard head
  initial begin
    cdb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else e = '0;
      check("cdb_transmit", 32'(cdb_transmit), 32'(e.t));
      check("cdb_id", 32'(cdb_id), 32'(e.id));
      check("cdb_val", 32'(cdb_val), 32'(e.val));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected test end");
    $fatal(1);
  end

  initial begin
    int                w;
    int                hit;
    logic [N-1:0]      h_v;
    logic [N-1:0][3:0] h_id;
    logic [N-1:0][7:0] h_val;
    logic              h_pv;
    logic [3:0]        h_pid;
    logic [N-1:0][3:0] ids3;
    logic [N-1:0][7:0] vals3;

    rst = 1'b0;
    fu_valid = '0; fu_id = '0; fu_val = '0;
    prf_req_valid = 1'b0; prf_req_id = 4'd0; force_low = 1'b0;
    last_prf_rdy = 1'b0;
    m_rr = 0; m_age = 0;
    for (int i = 0; i < 16; i++) prf_mem[i] = 8'($urandom);
    prf_mem[9] = 8'h42;
    ids3  = {4'd4, 4'd2, 4'd1};
    vals3 = {8'h40, 8'h20, 8'h10};

    #1;
    check("reset_cdb_transmit", 32'(cdb_transmit), 32'd0);
    check("reset_cdb_id", 32'(cdb_id), 32'd0);
    check("reset_cdb_val", 32'(cdb_val), 32'd0);
    check("reset_fu_ready", 32'(fu_ready), 32'd0);
    check("reset_prf_req_ready", 32'(prf_req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single FU1 broadcast, then idle
    run_cycle(3'b010, {4'd0, 4'd7, 4'd0}, {8'h00, 8'hA5, 8'h00}, 1'b0, 4'd0, 1'b0, w);
    run_cycle(3'b000, '0, '0, 1'b0, 4'd0, 1'b0, w);

    // FU2 broadcast, then reset lands while FU0 is being granted
    run_cycle(3'b100, {4'd1, 4'd0, 4'd0}, {8'h11, 8'h00, 8'h00}, 1'b0, 4'd0, 1'b0, w);
    fu_valid = 3'b001; fu_id = {4'd0, 4'd0, 4'd5}; fu_val = {8'h00, 8'h00, 8'h3C};
    #1;
    check("pre_reset_fu_ready", 32'(fu_ready), 32'(3'b001 << model_winner(3'b001, 1'b0)));
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_cdb_transmit", 32'(cdb_transmit), 32'd0);
    check("async_rst_cdb_id", 32'(cdb_id), 32'd0);
    check("async_rst_cdb_val", 32'(cdb_val), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    m_rr = 0; m_age = 0;

    // All FUs valid: rotation FU0, FU1, FU2, FU0
    for (int c = 0; c < 4; c++) run_cycle(3'b111, ids3, vals3, 1'b0, 4'd0, 1'b0, w);

    // PRF id 9 starved by FU traffic until aged
    hit = -1;
    for (int c = 0; c < 8 && hit < 0; c++) begin
      run_cycle(3'b111, ids3, vals3, 1'b1, 4'd9, 1'b0, w);
      if (last_prf_rdy) hit = c;
    end
    check("prf_aged_grant_cycle", 32'(hit), 32'd4);
    run_cycle(3'b111, ids3, vals3, 1'b0, 4'd0, 1'b0, w);

    // PRF id 3 on idle FUs, then FU2 arrives
    run_cycle(3'b000, '0, '0, 1'b1, 4'd3, 1'b0, w);
    run_cycle(3'b100, {4'd14, 4'd0, 4'd0}, {8'h77, 8'h00, 8'h00}, 1'b0, 4'd0, 1'b0, w);

    // PRF read port reports no data during grant
    run_cycle(3'b000, '0, '0, 1'b1, 4'd5, 1'b1, w);
    run_cycle(3'b000, '0, '0, 1'b0, 4'd0, 1'b0, w);

    // Random traffic; requesters hold until granted
    h_v = '0; h_id = '0; h_val = '0; h_pv = 1'b0; h_pid = 4'd0;
    for (int c = 0; c < 2000; c++) begin
      run_cycle(h_v, h_id, h_val, h_pv, h_pid, 1'($urandom_range(7) == 0), w);
      for (int i = 0; i < N; i++) begin
        if (!(h_v[i] && w != i)) begin
          h_v[i]   = ($urandom_range(99) < 45);
          h_id[i]  = 4'($urandom);
          h_val[i] = 8'($urandom);
        end
      end
      if (!(h_pv && w != N)) begin
        h_pv  = ($urandom_range(99) < 30);
        h_pid = 4'($urandom);
      end
    end

    for (int c = 0; c < 3; c++) run_cycle(3'b000, '0, '0, 1'b0, 4'd0, 1'b0, w);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Single-owner scheduler for the shared 12-bit CDB (4-bit tag, 8-bit value).
- Each cycle, grants at most one of NUM_FU functional-unit result broadcasts or one PRF read-out request.
- Drives the PRF's requesting/requested_id read port and registers the winning tag/value onto the shared CDB.
- The shared CDB loops back to the PRF and reservation stations as the shared_cdb_* feedback.

Parameters:
- NUM_FU, 3, number of functional-unit requesters (2..8).
- AGE_MAX, 4, cycles a pending PRF request may lose before it takes absolute priority (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- fu_valid  in  NUM_FU  FU i holds a result to broadcast.
- fu_id  in  NUM_FU×4  destination physical tag per FU.
- fu_val  in  NUM_FU×8  result value per FU.
- fu_ready  out  NUM_FU  grant; transfer occurs when fu_valid[i] && fu_ready[i].
- prf_req_valid  in  1  request to re-broadcast a PRF entry.
- prf_req_id  in  4  PRF tag to re-broadcast.
- prf_req_ready  out  1  grant for the PRF request.
- prf_requesting  out  1  to PRF read port.
- prf_requested_id  out  4  to PRF read port.
- prf_cdb_transmit  in  1  PRF read-port valid (combinational echo).
- prf_cdb_id  in  4  PRF read-port tag.
- prf_cdb_val  in  8  PRF read-port data.
- cdb_transmit  out  1  shared CDB valid (registered).
- cdb_id  out  4  shared CDB tag (registered).
- cdb_val  out  8  shared CDB value (registered).

Behaviour:
- **State:**
  - rr_ptr: log2(NUM_FU) bits, next FU to favour.
  - age_cnt: 4 bits, saturating.
  - Output registers cdb_transmit/cdb_id/cdb_val.
- **Reset (rst=0, async):**
  - rr_ptr=0, age_cnt=0.
  - cdb_transmit=0, cdb_id=0, cdb_val=0.
  - Any broadcast in flight is dropped.
  - Combinational outputs follow the inputs with the registers at reset values.
- **Grant selection, combinational, at most one grant per cycle:**
  1. If prf_req_valid && age_cnt>=AGE_MAX, the PRF wins.
  2. Else the first fu_valid[i] scanning i = rr_ptr, rr_ptr+1, ... mod NUM_FU wins.
  3. Else, if prf_req_valid, the PRF wins.
  4. Else there is no grant.
- **Grant outputs:**
  - fu_ready is one-hot or zero.
  - prf_req_ready=1 only on a PRF win.
  - prf_requesting = prf_req_ready; prf_requested_id = prf_req_id when granted, else 0.
- **FU win at edge t:**
  - cdb_transmit=1, cdb_id=fu_id[i], cdb_val=fu_val[i], visible from t+1. Latency is 1 cycle.
  - rr_ptr <= (i+1) mod NUM_FU.
- **PRF win at edge t:**
  - cdb registers load prf_cdb_id/prf_cdb_val, gated by prf_cdb_transmit; if it is low, cdb_transmit=0. Latency is 1 cycle.
  - rr_ptr unchanged.
  - age_cnt <= 0.
- **No grant:** cdb_transmit <= 0; cdb_id and cdb_val <= 0.
- **Aging:**
  - age_cnt increments each edge where prf_req_valid=1 and the PRF is not granted.
  - Saturates at 15.
  - Clears when prf_req_valid=0 or on a PRF grant.
- **Requester rules (bench checks, RTL does not):**
  - fu_valid, fu_id and fu_val stay stable until granted.
  - prf_req_id stays stable until granted.
- fu_ready never depends on its own fu_valid only; it is a function of all valid inputs, rr_ptr and age_cnt. There is no combinational loop.
- Back-to-back grants are allowed every cycle. Throughput is 1 broadcast/cycle.
- Tag collisions between requesters are not arbitrated and are passed through as-is.

Test Plan:
1. Reset mid-broadcast: grant FU0 (id=5, val=0x3C), assert rst=0 before the next edge completes -> cdb_transmit=0, cdb_id=0, cdb_val=0 immediately. After release, rr_ptr=0 and FU0 is granted first.
2. Single FU1 valid, id=7, val=0xA5 -> fu_ready=3'b010 the same cycle. Next cycle cdb_transmit=1, cdb_id=7, cdb_val=0xA5; the following cycle cdb_transmit=0.
3. All three FUs valid continuously, rr_ptr=0 -> grants FU0, FU1, FU2, FU0 on consecutive cycles. The CDB shows each FU's id/val one cycle after its grant.
4. PRF request id=9 (PRF entry 9 = 0x42) with all FUs continuously valid, AGE_MAX=4 -> PRF loses 4 cycles and age_cnt reaches 4. On the 5th cycle prf_req_ready=1, prf_requesting=1, prf_requested_id=9. Next cycle cdb_id=9, cdb_val=0x42; age_cnt=0, rr_ptr unchanged.
5. PRF request id=3 with no FU valid -> granted the same cycle with age_cnt=0. A simultaneous FU2 arrival the next cycle is granted then, and the CDB shows tag 3 followed by FU2's tag on consecutive cycles.
6. prf_cdb_transmit forced low during a PRF grant -> cdb_transmit=0 the next cycle; the grant still clears age_cnt.
